dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-port round-robin arbiter sharing the single DataMemory (clk, adress, wdata, rdata, MemWrite, MemRead).
//  Port 0 = CPU load/store path; port 1 = loader/debug path (memory preload, dumps).
//  Accepts one request per access slot, drives the memory for exactly one cycle, returns read data
//  with a registered rvalid pulse. Also filters out-of-range addresses.
// PARAMETERS
//  DATA_W  32   data width of memory and ports
//  ADDR_W  32   address width of ports and memory
//  DEPTH   256  memory words; addresses >= DEPTH are out of range
// PORTS
//  clk          in   1       clock; all state changes on rising edge
//  rst          in   1       synchronous, active-high reset
//  p0_req       in   1       port 0 request; hold with p0_we/addr/wdata stable until p0_gnt
//  p0_we        in   1       1 = write, 0 = read
//  p0_addr      in   ADDR_W  word address
//  p0_wdata     in   DATA_W  write data
//  p0_lock      in   1       keep grant ownership (DMEM_ARB_LOCK_EN only)
//  p0_gnt       out  1       1-cycle pulse: request accepted
//  p0_rvalid    out  1       1-cycle pulse: access complete (reads and writes)
//  p0_rdata     out  DATA_W  read data, valid with p0_rvalid, held until next p0 completion
//  p0_err       out  1       with p0_rvalid: address was out of range
//  p1_*         same set as p0_* for port 1
//  mem_adress   out  ADDR_W  to DataMemory adress
//  mem_wdata    out  DATA_W  to DataMemory wdata
//  mem_MemWrite out  1       to DataMemory MemWrite
//  mem_MemRead  out  1       to DataMemory MemRead
//  mem_rdata    in   DATA_W  from DataMemory rdata (combinational read)
// BEHAVIOUR
//  FSM: IDLE -> ACCESS -> IDLE. One access per 2 cycles max.
//  IDLE, cycle N: if any req, pick winner, latch {port, we, addr, wdata} into cmd reg, -> ACCESS.
//   No req: stay IDLE.
//  ACCESS, cycle N+1: winner gnt=1; mem_* driven from cmd reg; MemRead=~we, MemWrite=we
//   (both 0 if out of range). Edge ending N+1: write commits, mem_rdata captured, -> IDLE.
//  Cycle N+2: winner rvalid=1; rdata = captured data (0 on write or out of range); err = addr>=DEPTH.
//  Requester drops req at the edge ending the gnt cycle; a req still high in N+2 is a new request.
//  Arbitration: single req wins. Both req: port != last_gnt wins. last_gnt updates on every grant.
//  Idle mem_* outputs: MemRead=MemWrite=0, mem_adress/mem_wdata hold last cmd value.
//  Reset values: state=IDLE, last_gnt=1 (port 0 wins first tie), all gnt/rvalid/err=0,
//   rdata=0, mem_*=0.
//  Reset mid-operation: in-flight access abandoned, no rvalid. mem_MemWrite gated by ~rst
//   (no write commits in a rst cycle).
//  Address compare uses full ADDR_W; no wrap; mem_adress passes the address unmodified.
// CONFIGURATION
//  DMEM_ARB_LOCK_EN defined:
//   If the last grant went to port X and pX_lock=1 in IDLE, only port X can win.
//   Other port waits (even if X is idle) until pX_lock drops.
//  Not defined: p*_lock inputs ignored; pure round-robin.
// TESTING
//  1 p0 write addr=1 wdata=8, then p0 read addr=1 -> p0_gnt in N+1, MemWrite 1 cycle,
//    read p0_rvalid in N+2 with p0_rdata=8, err=0.
//  2 p0, p1 req same cycle after reset (p0 wr 7<-9, p1 rd 7) -> p0 granted first;
//    p1 granted 2 cycles later; p1_rdata=9.
//  3 Both hold req continuously for 8 slots -> grants alternate p0,p1,p0,p1;
//    never 2 consecutive to one port.
//  4 p1 read addr=300 (DEPTH=256) -> MemRead/MemWrite stay 0; p1_rvalid=1, p1_err=1, p1_rdata=0.
//  5 rst high during ACCESS of a write to addr=15 -> no memory write; next cycle IDLE,
//    outputs at reset values; later read of 15 returns old data.
//  6 LOCK_EN: p1 granted with p1_lock=1, p0 req pending -> p1 regranted each slot,
//    p0 waits; p1_lock=0 -> p0 granted next slot. Without macro: alternation as in 3.

Source files
------------

// File: rtl/dmem_arb_if.sv
// Requester-side bus of one dmem_arbiter port: request payload in, grant/completion out.
interface dmem_arb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              lock;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata, lock,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, lock,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single DataMemory, one access per two cycles.
// Optional grant locking is enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arb_if.slave         p0,
  dmem_arb_if.slave         p1,
  output logic [ADDR_W-1:0] mem_adress,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t            r_state;
  logic              r_last;
  logic [1:0]        r_gnt;
  logic [1:0]        r_rvalid;
  logic [1:0]        r_err;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_cmd_we;
  logic              r_cmd_oor;
  logic [ADDR_W-1:0] r_adress;
  logic [DATA_W-1:0] r_wdata;
  logic              r_memrd;
  logic              r_memwr;

  logic              w_any;
  logic              w_win;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_oor;
  logic [DATA_W-1:0] w_rd_data;

  // Winner selection: lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    w_any = p0.req | p1.req;
    w_win = (p0.req & p1.req) ? ~r_last : p1.req;
`ifdef DMEM_ARB_LOCK_EN
    if (r_last ? p1.lock : p0.lock) begin
      w_any = r_last ? p1.req : p0.req;
      w_win = r_last;
    end
`endif
  end

`ifndef DMEM_ARB_LOCK_EN
  logic w_unused_lock;
  assign w_unused_lock = p0.lock | p1.lock;
`endif

  assign w_we      = w_win ? p1.we    : p0.we;
  assign w_addr    = w_win ? p1.addr  : p0.addr;
  assign w_wdata   = w_win ? p1.wdata : p0.wdata;
  assign w_oor     = (w_addr >= ADDR_W'(DEPTH));
  assign w_rd_data = (r_cmd_we | r_cmd_oor) ? '0 : mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_gnt     <= '0;
      r_rvalid  <= '0;
      r_err     <= '0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_cmd_we  <= 1'b0;
      r_cmd_oor <= 1'b0;
      r_adress  <= '0;
      r_wdata   <= '0;
      r_memrd   <= 1'b0;
      r_memwr   <= 1'b0;
    end else begin
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_err    <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state      <= S_ACCESS;
            r_last       <= w_win;
            r_gnt[w_win] <= 1'b1;
            r_cmd_we     <= w_we;
            r_cmd_oor    <= w_oor;
            r_adress     <= w_addr;
            r_wdata      <= w_wdata;
            r_memrd      <= ~w_we & ~w_oor;
            r_memwr      <= w_we & ~w_oor;
          end
        end
        S_ACCESS: begin
          // r_last still names the port owning this access.
          r_state          <= S_IDLE;
          r_memrd          <= 1'b0;
          r_memwr          <= 1'b0;
          r_rvalid[r_last] <= 1'b1;
          r_err[r_last]    <= r_cmd_oor;
          if (r_last) r_rdata1 <= w_rd_data;
          else        r_rdata0 <= w_rd_data;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign p0.gnt    = r_gnt[0];
  assign p1.gnt    = r_gnt[1];
  assign p0.rvalid = r_rvalid[0];
  assign p1.rvalid = r_rvalid[1];
  assign p0.err    = r_err[0];
  assign p1.err    = r_err[1];
  assign p0.rdata  = r_rdata0;
  assign p1.rdata  = r_rdata1;

  // Write strobe is gated by reset so an abandoned access never commits.
  assign mem_adress   = r_adress;
  assign mem_wdata    = r_wdata;
  assign mem_MemRead  = r_memrd;
  assign mem_MemWrite = r_memwr & ~rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: constant vector table, directed corner sequences,
// and random two-port traffic checked by a transaction-level memory/arbitration model.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_clr = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic          t_req[2];
  logic          t_we[2];
  logic          t_lock[2];
  logic [AW-1:0] t_addr[2];
  logic [DW-1:0] t_wdata[2];

  dmem_arb_if #(.DATA_W(DW), .ADDR_W(AW)) u_p0 ();
  dmem_arb_if #(.DATA_W(DW), .ADDR_W(AW)) u_p1 ();

  assign u_p0.req = t_req[0];  assign u_p1.req = t_req[1];
  assign u_p0.we = t_we[0];    assign u_p1.we = t_we[1];
  assign u_p0.lock = t_lock[0]; assign u_p1.lock = t_lock[1];
  assign u_p0.addr = t_addr[0]; assign u_p1.addr = t_addr[1];
  assign u_p0.wdata = t_wdata[0]; assign u_p1.wdata = t_wdata[1];

  logic [AW-1:0] mem_adress;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_MemWrite;
  logic          mem_MemRead;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .p0(u_p0), .p1(u_p1),
    .mem_adress(mem_adress), .mem_wdata(mem_wdata),
    .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
    .mem_rdata(mem_rdata)
  );

  // DataMemory stand-in: synchronous write, combinational read.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (mem_MemWrite && mem_adress < 32'(DEPTH)) begin
      ram[mem_adress[7:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_adress < 32'(DEPTH)) ? ram[mem_adress[7:0]] : '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: shadow memory updated in grant order, round-robin winner from the rules.
  logic [DW-1:0] shadow [DEPTH];
  int            m_last = 1;
  logic [1:0]    e_gnt = '0;
  logic [1:0]    e_rv = '0;
  logic [DW-1:0] e_rd = '0;
  logic          e_er = 1'b0;
  logic          c_we = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  int            gnt_log[$];
  int            gnt_cyc[2] = '{0, 0};
  int            cyc = 0;

  always @(negedge clk) begin
    logic [1:0]    n_gnt, n_rv, gv, rv;
    logic [DW-1:0] n_rd;
    logic          n_er, inr, any;
    int            w;
    cyc++;
    gv = {u_p1.gnt, u_p0.gnt};
    rv = {u_p1.rvalid, u_p0.rvalid};
    if (ram_clr) for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    if (rst) begin
      m_last = 1;
      e_gnt  = '0;
      e_rv   = '0;
      chk("rst_no_write", 32'(mem_MemWrite), 32'd0);
    end else begin
      chk("gnt", 32'(gv), 32'(e_gnt));
      chk("rvalid", 32'(rv), 32'(e_rv));
      if (e_rv[0]) begin
        chk("p0_rdata", u_p0.rdata, e_rd);
        chk("p0_err", 32'(u_p0.err), 32'(e_er));
      end
      if (e_rv[1]) begin
        chk("p1_rdata", u_p1.rdata, e_rd);
        chk("p1_err", 32'(u_p1.err), 32'(e_er));
      end
      n_gnt = '0; n_rv = '0; n_rd = '0; n_er = 1'b0;
      if (e_gnt != 2'b00) begin
        w   = e_gnt[1] ? 1 : 0;
        inr = (c_addr < 32'(DEPTH));
        chk("mem_adress", mem_adress, c_addr);
        chk("mem_wdata", mem_wdata, c_wdata);
        chk("mem_MemRead", 32'(mem_MemRead), 32'(!c_we && inr));
        chk("mem_MemWrite", 32'(mem_MemWrite), 32'(c_we && inr));
        n_rv[w] = 1'b1;
        n_er    = !inr;
        n_rd    = (!c_we && inr) ? shadow[c_addr[7:0]] : '0;
        if (c_we && inr) shadow[c_addr[7:0]] = c_wdata;
        gnt_log.push_back(w);
        gnt_cyc[w] = cyc;
      end else begin
        chk("idle_MemRead", 32'(mem_MemRead), 32'd0);
        chk("idle_MemWrite", 32'(mem_MemWrite), 32'd0);
        any = u_p0.req | u_p1.req;
        if (u_p0.req && u_p1.req) w = 1 - m_last;
        else                      w = u_p1.req ? 1 : 0;
`ifdef DMEM_ARB_LOCK_EN
        if ((m_last == 1) ? u_p1.lock : u_p0.lock) begin
          any = (m_last == 1) ? u_p1.req : u_p0.req;
          w   = m_last;
        end
`endif
        if (any) begin
          n_gnt[w] = 1'b1;
          m_last   = w;
          c_we     = (w == 1) ? u_p1.we    : u_p0.we;
          c_addr   = (w == 1) ? u_p1.addr  : u_p0.addr;
          c_wdata  = (w == 1) ? u_p1.wdata : u_p0.wdata;
        end
      end
      e_gnt = n_gnt; e_rv = n_rv; e_rd = n_rd; e_er = n_er;
    end
  end

  function automatic logic gnt_of(int p);
    return (p == 1) ? u_p1.gnt : u_p0.gnt;
  endfunction
  function automatic logic rv_of(int p);
    return (p == 1) ? u_p1.rvalid : u_p0.rvalid;
  endfunction
  function automatic logic [31:0] rd_of(int p);
    return (p == 1) ? u_p1.rdata : u_p0.rdata;
  endfunction
  function automatic logic er_of(int p);
    return (p == 1) ? u_p1.err : u_p0.err;
  endfunction

  // Issue one request, hold until granted, drop after the grant cycle.
  task automatic p_req(input int p, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic lk);
    int n = 0;
    t_req[p] = 1'b1; t_we[p] = we; t_addr[p] = a; t_wdata[p] = d; t_lock[p] = lk;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt_of(p) && n < 100);
    if (!gnt_of(p)) begin
      n_tests++; n_fail++;
      $display("FAIL gnt_timeout p%0d: got no grant expected grant within 100 cycles", p);
    end
    @(posedge clk); #1;
    t_req[p] = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_p0_gnt", 32'(u_p0.gnt), 32'd0);
    chk("rst_p1_gnt", 32'(u_p1.gnt), 32'd0);
    chk("rst_p0_rvalid", 32'(u_p0.rvalid), 32'd0);
    chk("rst_p1_rvalid", 32'(u_p1.rvalid), 32'd0);
    chk("rst_p0_err", 32'(u_p0.err), 32'd0);
    chk("rst_p1_err", 32'(u_p1.err), 32'd0);
    chk("rst_p0_rdata", u_p0.rdata, 32'd0);
    chk("rst_p1_rdata", u_p1.rdata, 32'd0);
    chk("rst_mem_adress", mem_adress, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_MemRead", 32'(mem_MemRead), 32'd0);
    chk("rst_MemWrite", 32'(mem_MemWrite), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1);
  end

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 11;
  vec_t vt[NV];

  initial begin
    int base, p1_before, exp_before;
    vt[0]  = '{0, 1'b1, 32'd1,         32'd8,         32'd0,         1'b0};
    vt[1]  = '{0, 1'b0, 32'd1,         32'd0,         32'd8,         1'b0};
    vt[2]  = '{1, 1'b1, 32'd255,       32'hDEAD_BEEF, 32'd0,         1'b0};
    vt[3]  = '{1, 1'b0, 32'd255,       32'd0,         32'hDEAD_BEEF, 1'b0};
    vt[4]  = '{1, 1'b0, 32'd300,       32'd0,         32'd0,         1'b1};
    vt[5]  = '{0, 1'b1, 32'd256,       32'd5,         32'd0,         1'b1};
    vt[6]  = '{0, 1'b0, 32'd256,       32'd0,         32'd0,         1'b1};
    vt[7]  = '{1, 1'b0, 32'd0,         32'd0,         32'd0,         1'b0};
    vt[8]  = '{0, 1'b1, 32'd0,         32'h1234,      32'd0,         1'b0};
    vt[9]  = '{1, 1'b0, 32'd0,         32'd0,         32'h1234,      1'b0};
    vt[10] = '{1, 1'b0, 32'hFFFF_FF01, 32'd0,         32'd0,         1'b1};

    for (int p = 0; p < 2; p++) begin
      t_req[p] = 1'b0; t_we[p] = 1'b0; t_lock[p] = 1'b0; t_addr[p] = '0; t_wdata[p] = '0;
    end
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; ram_clr = 1'b0;
    @(negedge clk);
    chk_reset_vals();

    // Single-port accesses against constant expectations.
    @(posedge clk); #1;
    for (int i = 0; i < NV; i++) begin
      p_req(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d_rvalid", i), 32'(rv_of(vt[i].port)), 32'd1);
      chk($sformatf("vec%0d_rdata", i), rd_of(vt[i].port), vt[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er_of(vt[i].port)), 32'(vt[i].exp_err));
      @(posedge clk); #1;
    end

    // Simultaneous requests right after reset: p0 first, p1 two cycles later.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk); #1;
    fork
      p_req(0, 1'b1, 32'd7, 32'd9, 1'b0);
      p_req(1, 1'b0, 32'd7, 32'd0, 1'b0);
    join
    @(negedge clk);
    chk("t2_gnt_spacing", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'd2);
    chk("t2_p1_rvalid", 32'(u_p1.rvalid), 32'd1);
    chk("t2_p1_rdata", u_p1.rdata, 32'd9);

    // Continuous contention: grants alternate starting with p0.
    @(posedge clk); #1;
    base = gnt_log.size();
    fork
      begin
        for (int i = 0; i < 4; i++) p_req(0, 1'b0, 32'(i), 32'd0, 1'b0);
      end
      begin
        for (int i = 0; i < 4; i++) p_req(1, 1'b1, 32'(100 + i), $urandom, 1'b0);
      end
    join
    @(negedge clk);
    chk("t3_grant_count", 32'(gnt_log.size() - base), 32'd8);
    chk("t3_first_winner", 32'(gnt_log[base]), 32'd0);
    for (int k = 1; k < 8; k++)
      chk($sformatf("t3_alternate%0d", k), 32'(gnt_log[base + k] != gnt_log[base + k - 1]), 32'd1);

    // Reset during the ACCESS cycle of a write: nothing commits.
    @(posedge clk); #1;
    p_req(0, 1'b1, 32'd15, 32'hAA, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    t_req[0] = 1'b1; t_we[0] = 1'b1; t_addr[0] = 32'd15; t_wdata[0] = 32'h55;
    @(posedge clk); #1;
    rst = 1'b1; t_req[0] = 1'b0;
    @(negedge clk);
    chk("t5_gnt_in_access", 32'(u_p0.gnt), 32'd1);
    chk("t5_write_gated", 32'(mem_MemWrite), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk); #1;
    p_req(0, 1'b0, 32'd15, 32'd0, 1'b0);
    @(negedge clk);
    chk("t5_rvalid", 32'(u_p0.rvalid), 32'd1);
    chk("t5_old_data", u_p0.rdata, 32'hAA);

    // Lock: p1 keeps ownership while p1_lock is high (ignored without the macro).
    @(posedge clk); #1;
    p_req(1, 1'b0, 32'd3, 32'd0, 1'b1);
    base = gnt_log.size();
    fork
      p_req(0, 1'b0, 32'd4, 32'd0, 1'b0);
      begin
        for (int i = 0; i < 3; i++) p_req(1, 1'b0, 32'd5, 32'd0, 1'b1);
        t_lock[1] = 1'b0;
      end
    join
    t_lock[1] = 1'b0;
    @(negedge clk);
    p1_before = 0;
    for (int k = base; k < gnt_log.size(); k++) begin
      if (gnt_log[k] == 0) break;
      p1_before++;
    end
`ifdef DMEM_ARB_LOCK_EN
    exp_before = 3;
`else
    exp_before = 0;
`endif
    chk("t6_p1_grants_before_p0", 32'(p1_before), 32'(exp_before));
    chk("t6_total_grants", 32'(gnt_log.size() - base), 32'd4);

    // Random two-port traffic checked by the model.
    @(posedge clk); #1;
    fork
      for (int pp = 0; pp < 2; pp++) begin
        automatic int p = pp;
        fork
          for (int i = 0; i < 150; i++) begin
            automatic int r = int'($urandom_range(0, 9));
            automatic logic [31:0] a;
            if (r < 8)       a = $urandom_range(0, 31);
            else if (r == 8) a = $urandom_range(256, 300);
            else             a = $urandom;
            p_req(p, 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
            repeat ($urandom_range(0, 3)) begin
              @(posedge clk); #1;
            end
          end
        join_none
      end
    join
    wait fork;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
